// File: rtl/ram16k_bist.sv
// ram16k_bist -- March-style built-in self-test master for the RAM16K data memory.
//
// Runs four March elements over all 2^ADDR_W words:
//   W0   (ascending)  write P
//   R0W1 (ascending)  expect P,  write ~P
//   R1W0 (descending) expect ~P, write P
//   R0   (ascending)  expect P,  read only
// and stops at the first mismatch, recording where it happened.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start                request a run (sampled only in IDLE or DONE)
//   busy                 run in progress; this block owns the memory port
//   done, fail           result levels (fail valid while done=1)
//   fail_phase/addr/data first mismatch: element (1..3), address, value read
//   mem_load/address/in  RAM16K write side
//   mem_out              RAM16K combinational read data for mem_address
//   state_dbg            current FSM state, for checkers
//
// Control protocol: start is a level sampled on the rising edge only while
// the engine is idle (IDLE or DONE). Once accepted, busy is high from that
// edge until the edge that enters DONE; done then stays high until the next
// accepted start or reset. start seen while busy is ignored.

module ram16k_bist #(
  parameter int               ADDR_W  = 14,
  parameter int               DATA_W  = 16,
  parameter logic [DATA_W-1:0] PATTERN = 16'h5555
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [1:0]        fail_phase,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W0   = 3'd1,
    S_R0W1 = 3'd2,
    S_R1W0 = 3'd3,
    S_R0   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t              state;
  logic [ADDR_W-1:0]   addr;

  logic                check_en;
  logic [DATA_W-1:0]   expected;
  logic [1:0]          phase_code;
  logic                mismatch;
  logic                addr_last;

  // Per-element port drive and compare setup; everything here is a pure
  // function of registered state so the memory port never glitches on mem_out.
  always_comb begin
    busy       = 1'b0;
    mem_load   = 1'b0;
    mem_in     = '0;
    check_en   = 1'b0;
    expected   = PATTERN;
    phase_code = 2'd0;
    case (state)
      S_W0: begin
        busy     = 1'b1;
        mem_load = 1'b1;
        mem_in   = PATTERN;
      end
      S_R0W1: begin
        busy       = 1'b1;
        mem_load   = 1'b1;
        mem_in     = ~PATTERN;
        check_en   = 1'b1;
        expected   = PATTERN;
        phase_code = 2'd1;
      end
      S_R1W0: begin
        busy       = 1'b1;
        mem_load   = 1'b1;
        mem_in     = PATTERN;
        check_en   = 1'b1;
        expected   = ~PATTERN;
        phase_code = 2'd2;
      end
      S_R0: begin
        busy       = 1'b1;
        check_en   = 1'b1;
        expected   = PATTERN;
        phase_code = 2'd3;
      end
      default: ;
    endcase
  end

  // Address is forced to 0 outside a run so the system can take the port back.
  assign mem_address = busy ? addr : '0;
  assign mismatch    = check_en && (mem_out != expected);
  assign addr_last   = (addr == ADDR_MAX);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_phase <= 2'd0;
      fail_addr  <= '0;
      fail_data  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_W0;
            addr       <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_phase <= 2'd0;
            fail_addr  <= '0;
            fail_data  <= '0;
          end
        end

        S_W0: begin
          if (addr_last) begin
            state <= S_R0W1;
            addr  <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end

        S_R0W1: begin
          if (mismatch) begin
            state <= S_DONE;
          end else if (addr_last) begin
            // Address stays at max: R1W0 starts from the top.
            state <= S_R1W0;
          end else begin
            addr <= addr + 1'b1;
          end
        end

        S_R1W0: begin
          if (mismatch) begin
            state <= S_DONE;
          end else if (addr == '0) begin
            state <= S_R0;
          end else begin
            addr <= addr - 1'b1;
          end
        end

        S_R0: begin
          if (mismatch || addr_last) begin
            state <= S_DONE;
          end else begin
            addr <= addr + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Common handling for leaving a checking element: either a first
      // mismatch or the natural end of R0 completes the run.
      if (mismatch) begin
        fail       <= 1'b1;
        fail_phase <= phase_code;
        fail_addr  <= addr;
        fail_data  <= mem_out;
      end
      if (mismatch || (state == S_R0 && addr_last)) begin
        done <= 1'b1;
        addr <= '0;
      end
    end
  end

endmodule

// File: doc/ram16k_bist.md
# ram16k_bist

Built-in self-test engine that acts as the bus master for the RAM16K data memory. It drives the write side (`load`, `address`, `in`) and checks the read side (`out`). It runs a four-element March test over the whole address space and reports pass/fail with the first failing location. It sits between the RAM16K instance and the system, and owns the memory port while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 14, address width; the test covers 2^ADDR_W words.
- `DATA_W`, 16, word width.
- `PATTERN`, 16'h5555, background pattern P; its complement ~P is also used.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a test run; sampled only in IDLE or DONE.
- `busy`  out  1  test in progress; the memory port is owned by this block.
- `done`  out  1  level; high from test completion until the next start or reset.
- `fail`  out  1  level; valid while `done`=1; 1 = mismatch found.
- `fail_phase`  out  2  March element of the first mismatch (1=R0W1, 2=R1W0, 3=R0).
- `fail_addr`  out  ADDR_W  address of the first mismatch.
- `fail_data`  out  DATA_W  value read at the first mismatch.
- `mem_load`  out  1  RAM16K `load`.
- `mem_address`  out  ADDR_W  RAM16K `address`.
- `mem_in`  out  DATA_W  RAM16K `in`.
- `mem_out`  in  DATA_W  RAM16K `out`; combinational read of `mem_address` in the same cycle.

## Operation
States:
- IDLE (phase 0)
- W0: ascending; write P.
- R0W1: ascending; expect P, write ~P.
- R1W0: descending; expect ~P, write P.
- R0: ascending; expect P, read only.
- DONE

Behaviour:
- Each state visits one address per cycle. In read-write states, the block compares `mem_out` and asserts `mem_load` with the new data in the same cycle. The write lands at the closing edge.
- `mem_load`=1 in W0, R0W1 and R1W0, including on a mismatching cycle. `mem_load`=0 in R0, IDLE and DONE.
- Address sequence: W0 and R0W1 run 0 to 2^ADDR_W-1. R1W0 runs 2^ADDR_W-1 down to 0. R0 runs 0 to 2^ADDR_W-1.
- Transitions:
  - W0 to R0W1 at the last address, with the address reset to 0.
  - R0W1 to R1W0 at the last address, with the address held at max.
  - R1W0 to R0 at address 0, with the address set to 0.
  - R0 to DONE at the last address.
- Mismatch (`mem_out` differs from expected in R0W1, R1W0 or R0):
  - Capture the phase, `mem_address` and `mem_out` into the `fail_*` registers.
  - Set `fail`=1 and go directly to DONE. Only the first mismatch is recorded.
- Start handling:
  - `start` in IDLE or DONE goes to W0 at address 0 and clears `done`, `fail` and the `fail_*` registers.
  - `start` while busy is ignored.
- In IDLE and DONE, `mem_address`, `mem_in` and `mem_load` are 0, so the system may mux the port back.

## Timing
- Reset (asynchronous, any state): state=IDLE.
  - `busy`, `done`, `fail` = 0.
  - `fail_phase`, `fail_addr`, `fail_data` = 0.
  - `mem_load`, `mem_address`, `mem_in` = 0.
- Reset mid-run abandons the test immediately. Memory contents are then undefined.
- `start` sampled high at edge E0: `busy`=1 and W0 at address 0 from E0 onward.
- Passing run:
  - Each element lasts exactly N=2^ADDR_W cycles.
  - DONE is entered at edge E0+4N, with `busy`=0, `done`=1 and `fail`=0.
  - For the default ADDR_W=14, this is 65536 cycles.
- Failing run: DONE is entered at the edge closing the mismatching cycle; `busy` falls at that edge.
- The address counter is ADDR_W bits. Ascending wrap and descending underflow never occur, because the element-end transitions pre-empt them.
- `done` and `fail` are registered with no glitches. `mem_*` outputs derive from registered state; only the compare result depends on `mem_out`.

## Test plan
Bench uses ADDR_W=4 (N=16) and a behavioural RAM with optional stuck-at fault injection.
- Clean pass: reset, pulse `start` → `busy` for 64 cycles; `done`=1, `fail`=0 at edge E0+64; all 16 words read 16'h5555.
- Stuck-at-1, bit 1, address 3 → `fail`=1, `fail_phase`=1, `fail_addr`=3, `fail_data`=16'h5557; DONE at edge E0+16+3+1.
- Stuck-at-1, bit 0, address 5 → `fail_phase`=2, `fail_addr`=5, `fail_data`=16'hAAAB; DONE reached on the 11th R1W0 cycle (counting 15 down to 5).
- Stuck-at-0, bit 15, address 0 → `fail_phase`=2, `fail_addr`=0, `fail_data`=16'h2AAA, on the last R1W0 cycle.
- `start` held high throughout the run → single run, no restart, `done` at E0+64. A `start` pulse in DONE clears `done`, `fail` and the `fail_*` registers next edge and reruns.
- `reset_n` low at cycle 20 mid-run → all outputs 0 asynchronously; state IDLE; a subsequent `start` completes a clean pass.
